// File: rtl/i2s_stereo_tx_if.sv
// Sample-pair handshake between the audio decode path and the I2S serialiser.
interface i2s_stereo_tx_if #(
    parameter int unsigned SAMPLE_WIDTH = 16
);
    logic [SAMPLE_WIDTH-1:0] l_sample;
    logic [SAMPLE_WIDTH-1:0] r_sample;
    logic                    sample_valid;
    logic                    sample_ready_c;

    modport master (
        output l_sample,
        output r_sample,
        output sample_valid,
        input  sample_ready_c
    );

    modport slave (
        input  l_sample,
        input  r_sample,
        input  sample_valid,
        output sample_ready_c
    );
endinterface

// File: rtl/i2s_stereo_tx.sv
// I2S stereo transmitter for a PCM5102A: one-entry sample hold, BCK/LCK generation,
// MSB-first serialisation with the one-bit I2S delay, and underrun flagging.
module i2s_stereo_tx #(
    parameter int unsigned SAMPLE_WIDTH = 16,
    parameter int unsigned SLOT_WIDTH   = 32,
    parameter int unsigned BCK_DIV      = 4
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            enable_i,
    i2s_stereo_tx_if.slave  smp,
    output logic            bck_o,
    output logic            lck_o,
    output logic            din_o,
    output logic            frame_start_o,
    output logic            underrun_o
);

    localparam int unsigned FRAME_BITS = 2 * SLOT_WIDTH;
    localparam int unsigned BIT_W      = $clog2(FRAME_BITS);
    localparam int unsigned DIV_W      = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic                    hold_full_q, hold_full_d;
    logic [SAMPLE_WIDTH-1:0] hold_l_q, hold_l_d;
    logic [SAMPLE_WIDTH-1:0] hold_r_q, hold_r_d;
    logic [SAMPLE_WIDTH-1:0] shift_l_q, shift_l_d;
    logic [SAMPLE_WIDTH-1:0] shift_r_q, shift_r_d;
    logic [DIV_W-1:0]        div_cnt_q, div_cnt_d;
    logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic                    bck_q, bck_d;
    logic                    lck_q, lck_d;
    logic                    din_q, din_d;
    logic                    frame_start_q, frame_start_d;
    logic                    underrun_q, underrun_d;

    logic                    accept;
    logic                    load;
    logic [BIT_W-1:0]        nxt_bit;
    logic [BIT_W-1:0]        slot_k;
    logic                    nxt_right;
    logic                    in_data;

    assign smp.sample_ready_c = enable_i && !hold_full_q;
    assign accept             = smp.sample_valid && smp.sample_ready_c;

    // State register and all registered outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q       <= ST_IDLE;
            hold_full_q   <= 1'b0;
            hold_l_q      <= '0;
            hold_r_q      <= '0;
            shift_l_q     <= '0;
            shift_r_q     <= '0;
            div_cnt_q     <= '0;
            bit_cnt_q     <= '0;
            bck_q         <= 1'b0;
            lck_q         <= 1'b0;
            din_q         <= 1'b0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_full_q   <= hold_full_d;
            hold_l_q      <= hold_l_d;
            hold_r_q      <= hold_r_d;
            shift_l_q     <= shift_l_d;
            shift_r_q     <= shift_r_d;
            div_cnt_q     <= div_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            bck_q         <= bck_d;
            lck_q         <= lck_d;
            din_q         <= din_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
        end
    end

    // Next-state: clock division, bit sequencing, frame loads and the hold register.
    always_comb begin
        state_d       = state_q;
        hold_full_d   = hold_full_q;
        hold_l_d      = hold_l_q;
        hold_r_d      = hold_r_q;
        shift_l_d     = shift_l_q;
        shift_r_d     = shift_r_q;
        div_cnt_d     = div_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        bck_d         = bck_q;
        lck_d         = lck_q;
        din_d         = din_q;
        frame_start_d = 1'b0;
        underrun_d    = 1'b0;
        load          = 1'b0;

        nxt_bit   = bit_cnt_q + BIT_W'(1);
        nxt_right = (nxt_bit >= BIT_W'(SLOT_WIDTH));
        slot_k    = nxt_right ? (nxt_bit - BIT_W'(SLOT_WIDTH)) : nxt_bit;
        in_data   = (slot_k >= BIT_W'(1)) && (slot_k <= BIT_W'(SAMPLE_WIDTH));

        if (accept) begin
            hold_l_d    = smp.l_sample;
            hold_r_d    = smp.r_sample;
            hold_full_d = 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                bck_d     = 1'b0;
                lck_d     = 1'b0;
                din_d     = 1'b0;
                div_cnt_d = '0;
                bit_cnt_d = '0;
                if (enable_i) begin
                    state_d = ST_RUN;
                    load    = 1'b1;
                end
            end
            ST_RUN: begin
                if (div_cnt_q == DIV_W'(BCK_DIV - 1)) begin
                    div_cnt_d = '0;
                    bck_d     = !bck_q;
                    // Falling BCK edge: advance the bit and present the next DIN/LCK.
                    if (bck_q) begin
                        if (bit_cnt_q == BIT_W'(FRAME_BITS - 1)) begin
                            bit_cnt_d = '0;
                            lck_d     = 1'b0;
                            din_d     = 1'b0;
                            if (enable_i) begin
                                load = 1'b1;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end else begin
                            bit_cnt_d = nxt_bit;
                            lck_d     = nxt_right;
                            din_d     = 1'b0;
                            if (in_data) begin
                                if (nxt_right) begin
                                    din_d     = shift_r_q[SAMPLE_WIDTH-1];
                                    shift_r_d = shift_r_q << 1;
                                end else begin
                                    din_d     = shift_l_q[SAMPLE_WIDTH-1];
                                    shift_l_d = shift_l_q << 1;
                                end
                            end
                        end
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
        endcase

        // An empty hold at a load sends a silent frame; accept never coincides with a full hold.
        if (load) begin
            frame_start_d = 1'b1;
            if (hold_full_q) begin
                shift_l_d   = hold_l_q;
                shift_r_d   = hold_r_q;
                hold_full_d = 1'b0;
            end else begin
                shift_l_d  = '0;
                shift_r_d  = '0;
                underrun_d = 1'b1;
            end
        end
    end

    assign bck_o         = bck_q;
    assign lck_o         = lck_q;
    assign din_o         = din_q;
    assign frame_start_o = frame_start_q;
    assign underrun_o    = underrun_q;

endmodule
